// File: rtl/shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Width of the shift-amount field (number of log stages) for a data width.
    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

    // Log-stage index at which pipeline register j sits: ceil(sh_w*j/pipe_stages).
    function automatic int stage_boundary(input int j, input int sh_w, input int pipe_stages);
        return (sh_w * j + pipe_stages - 1) / pipe_stages;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for pipelined_shifter.
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic                     i_valid;
    logic                     o_ready;
    logic [WIDTH-1:0]         i_data;
    logic [$clog2(WIDTH)-1:0] i_shamt;
    shift_op_e                i_op;
    logic [TAG_W-1:0]         i_tag;
    logic                     o_valid;
    logic                     i_ready;
    logic [WIDTH-1:0]         o_data;
    logic [TAG_W-1:0]         o_tag;

    modport master (
        output i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
        input  o_ready, o_valid, o_data, o_tag
    );

    modport slave (
        input  i_valid, i_data, i_shamt, i_op, i_tag, i_ready,
        output o_ready, o_valid, o_data, o_tag
    );
endinterface

// File: rtl/shifter_log_stage.sv
// One log stage of the right-shift core: shifts right by DIST when en_i is set,
// filling with fill_i, or rotating when rot_i is set. Purely combinational.
module shifter_log_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             fill_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] data_o
);
    // Select between pass-through, fill shift and rotate.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            if (rot_i) begin
                data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            end else begin
                data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
            end
        end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to make op 11 a rotate-right; otherwise op 11 yields zero.
// SLL runs through the right-shift core by bit-reversing at entry and before the last register.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    pipelined_shifter_if.slave  bus
);
    localparam int SH_W = shamt_w(WIDTH);
    localparam int P    = PIPE_STAGES;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [P-1:0]     valid_q;
    logic [P-1:0]     in_valid;
    logic [P-1:0]     adv;
    logic [P-1:0]     load;
    logic [WIDTH-1:0] data_q  [P];
    logic [WIDTH-1:0] data_d  [P];
    logic [TAG_W-1:0] tag_q   [P];
    logic [TAG_W-1:0] tag_d   [P];
    logic [SH_W-1:0]  shamt_q [P];
    logic [SH_W-1:0]  shamt_d [P];
    logic [P-1:0]     rev_q, rev_d;
    logic [P-1:0]     fill_q, fill_d;
    logic [P-1:0]     rot_q, rot_d;

    logic [WIDTH-1:0] entry_data;
    logic             entry_rev;
    logic             entry_fill;
    logic             entry_rot;

    // Decode the op at acceptance into per-beat control bits; sign is captured here.
    always_comb begin
        entry_rev  = (bus.i_op == SH_SLL);
        entry_fill = (bus.i_op == SH_SRA) & bus.i_data[WIDTH-1];
        entry_data = entry_rev ? bit_rev(bus.i_data) : bus.i_data;
`ifdef SHIFTER_ROTATE_EN
        entry_rot  = (bus.i_op == SH_ROR);
`else
        entry_rot  = 1'b0;
        if (bus.i_op == SH_ROR) begin
            entry_data = '0;
        end
`endif
    end

    for (genvar j = 0; j < P; j++) begin : g_stage
        localparam int LO = stage_boundary(j, SH_W, P);
        localparam int HI = stage_boundary(j + 1, SH_W, P);

        logic [WIDTH-1:0] src_data;
        logic [SH_W-1:0]  src_shamt;
        logic [TAG_W-1:0] src_tag;
        logic             src_rev;
        logic             src_fill;
        logic             src_rot;
        logic [WIDTH-1:0] chain [SH_W+1];

        if (j == 0) begin : g_src
            assign src_data    = entry_data;
            assign src_shamt   = bus.i_shamt;
            assign src_tag     = bus.i_tag;
            assign src_rev     = entry_rev;
            assign src_fill    = entry_fill;
            assign src_rot     = entry_rot;
            assign in_valid[j] = bus.i_valid;
        end else begin : g_src
            assign src_data    = data_q[j-1];
            assign src_shamt   = shamt_q[j-1];
            assign src_tag     = tag_q[j-1];
            assign src_rev     = rev_q[j-1];
            assign src_fill    = fill_q[j-1];
            assign src_rot     = rot_q[j-1];
            assign in_valid[j] = valid_q[j-1];
        end

        assign chain[0] = src_data;
        for (genvar k = 0; k < SH_W; k++) begin : g_log
            if (k >= LO && k < HI) begin : g_on
                shifter_log_stage #(
                    .WIDTH (WIDTH),
                    .DIST  (2 ** k)
                ) u_log (
                    .data_i (chain[k]),
                    .en_i   (src_shamt[k]),
                    .fill_i (src_fill),
                    .rot_i  (src_rot),
                    .data_o (chain[k+1])
                );
            end else begin : g_thru
                assign chain[k+1] = chain[k];
            end
        end

        // The last register drives o_data, so SLL un-reversal happens ahead of it.
        if (j == P - 1) begin : g_out
            assign data_d[j] = src_rev ? bit_rev(chain[SH_W]) : chain[SH_W];
        end else begin : g_mid
            assign data_d[j] = chain[SH_W];
        end
        assign tag_d[j]   = src_tag;
        assign shamt_d[j] = src_shamt;
        assign rev_d[j]   = src_rev;
        assign fill_d[j]  = src_fill;
        assign rot_d[j]   = src_rot;
    end

    // Occupancy: a stage advances when it holds a beat and the next slot frees up.
    always_comb begin
        adv      = '0;
        adv[P-1] = valid_q[P-1] & bus.i_ready;
        for (int j = P - 2; j >= 0; j--) begin
            adv[j] = valid_q[j] & (~valid_q[j+1] | adv[j+1]);
        end
        load = ~valid_q | adv;
    end

    // Stage registers; payload only captured when a beat actually moves in.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            rev_q   <= '0;
            fill_q  <= '0;
            rot_q   <= '0;
            for (int j = 0; j < P; j++) begin
                data_q[j]  <= '0;
                tag_q[j]   <= '0;
                shamt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < P; j++) begin
                if (load[j]) begin
                    valid_q[j] <= in_valid[j];
                    if (in_valid[j]) begin
                        data_q[j]  <= data_d[j];
                        tag_q[j]   <= tag_d[j];
                        shamt_q[j] <= shamt_d[j];
                        rev_q[j]   <= rev_d[j];
                        fill_q[j]  <= fill_d[j];
                        rot_q[j]   <= rot_d[j];
                    end
                end
            end
        end
    end

    assign bus.o_ready = load[0];
    assign bus.o_valid = valid_q[P-1];
    assign bus.o_data  = data_q[P-1];
    assign bus.o_tag   = tag_q[P-1];

endmodule
